// File: rtl/counter_v2_pkg.sv
`default_nettype none
// ============================================================================
// counter_v2_pkg : pin-map indices and shared types for tt_um_counter_v2
// Revision: 1.0
// ============================================================================
package counter_v2_pkg;

  // ui_in control bit positions
  localparam int EN    = 0;
  localparam int DIR   = 1;
  localparam int MODE  = 2;
  localparam int LOAD  = 3;
  localparam int CLR   = 4;
  localparam int PS_LO = 5;
  localparam int PS_HI = 6;

  // uio_out status bit positions
  localparam int TC  = 7;
  localparam int SAT = 6;

  localparam logic [7:0] UIO_OE_VAL = 8'hC0;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// tick_prescaler : free-running power-of-two prescaler producing count ticks
// Revision: 1.0
// ============================================================================
module tick_prescaler #(
  parameter int PS_STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  input  logic [1:0] sel,
  output logic       tick
);

  localparam int PW = 3 * PS_STEP;

  logic [PW-1:0] r_cnt;
  logic          w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

  // A tick fires on the enabled cycle that completes a run of all-ones low bits
  always_comb begin
    w_hit = 1'b1;
    case (sel)
      2'd0:    w_hit = 1'b1;
      2'd1:    w_hit = &r_cnt[PS_STEP-1:0];
      2'd2:    w_hit = &r_cnt[2*PS_STEP-1:0];
      default: w_hit = &r_cnt;
    endcase
  end

  assign tick = inc & w_hit;

endmodule
`default_nettype wire

// File: rtl/tt_um_counter_v2.sv
`default_nettype none
// ============================================================================
// tt_um_counter_v2 : up/down wrap/saturate counter with load, clear, prescaler
// Revision: 1.0
// ============================================================================
module tt_um_counter_v2 #(
  parameter int WIDTH   = 8,
  parameter int PS_STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import counter_v2_pkg::*;

  localparam logic [WIDTH-1:0] C_MAX = '1;

  logic [6:0]       r_sync1;
  logic [6:0]       r_sync2;
  logic             r_ld_q;
  logic             r_tc;
  logic             r_sat;
  logic [WIDTH-1:0] r_count;

  logic             w_en;
  logic             w_up;
  logic             w_clr;
  logic             w_load_ev;
  logic             w_tick;
  logic             w_at_bound;
  mode_e            w_mode;
  logic [7:0]       w_ld_ext;
  logic [7:0]       w_count_ext;
  logic [7:0]       w_uio;
  logic             w_unused;

  // Synchroniser runs regardless of ena so controls are fresh on resume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ui_in[6:0];
      r_sync2 <= r_sync1;
    end
  end

  assign w_en       = r_sync2[EN];
  assign w_up       = r_sync2[DIR];
  assign w_clr      = r_sync2[CLR];
  assign w_mode     = mode_e'(r_sync2[MODE]);
  assign w_load_ev  = r_sync2[LOAD] & ~r_ld_q;
  assign w_at_bound = w_up ? (r_count == C_MAX) : (r_count == '0);
  assign w_ld_ext   = {2'b00, uio_in[5:0]};

  tick_prescaler #(
    .PS_STEP (PS_STEP)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ena & w_en),
    .clr   (ena & (w_clr | w_load_ev)),
    .sel   (r_sync2[PS_HI:PS_LO]),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_q  <= 1'b0;
      r_tc    <= 1'b0;
      r_sat   <= 1'b0;
      r_count <= '0;
    end else if (ena) begin
      // The edge is consumed even when clear overrides the load
      r_ld_q <= r_sync2[LOAD];
      r_tc   <= 1'b0;
      r_sat  <= (w_mode == MODE_SAT) && w_en && w_at_bound;
      if (w_clr) begin
        r_count <= '0;
      end else if (w_load_ev) begin
        r_count <= w_ld_ext[WIDTH-1:0];
      end else if (w_tick) begin
        if (!w_at_bound) begin
          r_count <= w_up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
        end else if (w_mode == MODE_WRAP) begin
          r_count <= w_up ? '0 : C_MAX;
          r_tc    <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_count_ext              = '0;
    w_count_ext[WIDTH-1:0]   = r_count;
    w_uio                    = '0;
    w_uio[TC]                = r_tc;
    w_uio[SAT]               = r_sat;
  end

  assign uo_out   = w_count_ext;
  assign uio_out  = w_uio;
  assign uio_oe   = UIO_OE_VAL;
  assign w_unused = &{1'b0, ui_in[7], uio_in[7:6]};

endmodule
`default_nettype wire

// File: tb/tb_tt_um_counter_v2.sv
`default_nettype none
// ============================================================================
// tb_tt_um_counter_v2 : directed self-checking bench for tt_um_counter_v2
// Revision: 1.0
// ============================================================================
module tb_tt_um_counter_v2;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vecs;
  int errs;

  tt_um_counter_v2 #(
    .WIDTH   (8),
    .PS_STEP (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, landing 1ns after the last one
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #1;
    vecs++;
    if (uio_oe !== 8'hC0) begin errs++; $display("FAIL rst_oe: uio_oe=%h expected c0", uio_oe); end
    step(3);
    vecs++;
    if (uo_out !== 8'h00) begin errs++; $display("FAIL rst_count: uo_out=%h expected 00", uo_out); end
    vecs++;
    if (uio_out !== 8'h00) begin errs++; $display("FAIL rst_uio: uio_out=%h expected 00", uio_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_wrap_up;
    ui_in  = 8'h0A;
    uio_in = 8'h3F;
    step(3);
    vecs++;
    if (uo_out !== 8'h3F) begin errs++; $display("FAIL wrap_load: uo_out=%h expected 3f", uo_out); end
    ui_in = 8'h03;
    step(2);
    vecs++;
    if (uo_out !== 8'h3F) begin errs++; $display("FAIL wrap_latency: uo_out=%h expected 3f", uo_out); end
    step(1);
    vecs++;
    if (uo_out !== 8'h40) begin errs++; $display("FAIL wrap_first: uo_out=%h expected 40", uo_out); end
    step(191);
    vecs++;
    if (uo_out !== 8'hFF || uio_out[7] !== 1'b0) begin
      errs++; $display("FAIL wrap_max: uo_out=%h tc=%b expected ff tc=0", uo_out, uio_out[7]);
    end
    step(1);
    vecs++;
    if (uo_out !== 8'h00 || uio_out !== 8'h80) begin
      errs++; $display("FAIL wrap_tc: uo_out=%h uio_out=%h expected 00 80", uo_out, uio_out);
    end
    step(1);
    vecs++;
    if (uo_out !== 8'h01 || uio_out[7] !== 1'b0) begin
      errs++; $display("FAIL wrap_tc_pulse: uo_out=%h tc=%b expected 01 tc=0", uo_out, uio_out[7]);
    end
  endtask

  task automatic test_sat_down;
    ui_in  = 8'h0C;
    uio_in = 8'h02;
    step(3);
    vecs++;
    if (uo_out !== 8'h02) begin errs++; $display("FAIL sat_load: uo_out=%h expected 02", uo_out); end
    ui_in = 8'h05;
    step(2);
    vecs++;
    if (uo_out !== 8'h02 || uio_out[6] !== 1'b0) begin
      errs++; $display("FAIL sat_pre: uo_out=%h sat=%b expected 02 sat=0", uo_out, uio_out[6]);
    end
    step(1);
    vecs++;
    if (uo_out !== 8'h01) begin errs++; $display("FAIL sat_dec: uo_out=%h expected 01", uo_out); end
    step(1);
    vecs++;
    if (uo_out !== 8'h00 || uio_out[7] !== 1'b0) begin
      errs++; $display("FAIL sat_zero: uo_out=%h tc=%b expected 00 tc=0", uo_out, uio_out[7]);
    end
    for (int i = 0; i < 10; i++) begin
      step(1);
      vecs++;
      if (uo_out !== 8'h00 || uio_out !== 8'h40) begin
        errs++; $display("FAIL sat_hold[%0d]: uo_out=%h uio_out=%h expected 00 40", i, uo_out, uio_out);
      end
    end
  endtask

  task automatic test_load_clear_priority;
    ui_in = 8'h03;
    step(10);
    vecs++;
    if (uo_out !== 8'h08) begin errs++; $display("FAIL lc_run: uo_out=%h expected 08", uo_out); end
    ui_in  = 8'h1B;
    uio_in = 8'h2A;
    step(2);
    vecs++;
    if (uo_out !== 8'h0A) begin errs++; $display("FAIL lc_pre: uo_out=%h expected 0a", uo_out); end
    step(1);
    vecs++;
    if (uo_out !== 8'h00) begin errs++; $display("FAIL lc_clear_wins: uo_out=%h expected 00", uo_out); end
    ui_in = 8'h0B;
    step(3);
    vecs++;
    if (uo_out !== 8'h01) begin errs++; $display("FAIL lc_no_reload: uo_out=%h expected 01", uo_out); end
    step(1);
    vecs++;
    if (uo_out !== 8'h02) begin errs++; $display("FAIL lc_resume: uo_out=%h expected 02", uo_out); end
  endtask

  task automatic test_prescaler;
    ui_in = 8'h32;
    step(4);
    vecs++;
    if (uo_out !== 8'h00) begin errs++; $display("FAIL ps_clear1: uo_out=%h expected 00", uo_out); end
    ui_in = 8'h23;
    step(17);
    vecs++;
    if (uo_out !== 8'h00) begin errs++; $display("FAIL ps1_15: uo_out=%h expected 00", uo_out); end
    step(1);
    vecs++;
    if (uo_out !== 8'h01) begin errs++; $display("FAIL ps1_16: uo_out=%h expected 01", uo_out); end
    step(47);
    vecs++;
    if (uo_out !== 8'h03) begin errs++; $display("FAIL ps1_63: uo_out=%h expected 03", uo_out); end
    step(1);
    vecs++;
    if (uo_out !== 8'h04) begin errs++; $display("FAIL ps1_64: uo_out=%h expected 04", uo_out); end
    ui_in = 8'h52;
    step(4);
    vecs++;
    if (uo_out !== 8'h00) begin errs++; $display("FAIL ps_clear2: uo_out=%h expected 00", uo_out); end
    ui_in = 8'h43;
    step(257);
    vecs++;
    if (uo_out !== 8'h00) begin errs++; $display("FAIL ps2_255: uo_out=%h expected 00", uo_out); end
    step(1);
    vecs++;
    if (uo_out !== 8'h01) begin errs++; $display("FAIL ps2_256: uo_out=%h expected 01", uo_out); end
  endtask

  task automatic test_ena_gating;
    ui_in = 8'h01;
    step(4);
    vecs++;
    if (uo_out !== 8'hFF || uio_out[7] !== 1'b1) begin
      errs++; $display("FAIL gate_wrap: uo_out=%h tc=%b expected ff tc=1", uo_out, uio_out[7]);
    end
    ena = 1'b0;
    step(10);
    vecs++;
    if (uo_out !== 8'hFF || uio_out !== 8'h80) begin
      errs++; $display("FAIL gate_mid: uo_out=%h uio_out=%h expected ff 80", uo_out, uio_out);
    end
    step(10);
    vecs++;
    if (uo_out !== 8'hFF || uio_out !== 8'h80) begin
      errs++; $display("FAIL gate_end: uo_out=%h uio_out=%h expected ff 80", uo_out, uio_out);
    end
    ena = 1'b1;
    step(1);
    vecs++;
    if (uo_out !== 8'hFE || uio_out[7] !== 1'b0) begin
      errs++; $display("FAIL gate_resume: uo_out=%h tc=%b expected fe tc=0", uo_out, uio_out[7]);
    end
    step(1);
    vecs++;
    if (uo_out !== 8'hFD) begin errs++; $display("FAIL gate_resume2: uo_out=%h expected fd", uo_out); end
  endtask

  task automatic test_reset_midcount;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vecs++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      errs++; $display("FAIL rst_async: uo_out=%h uio_out=%h expected 00 00", uo_out, uio_out);
    end
    vecs++;
    if (uio_oe !== 8'hC0) begin errs++; $display("FAIL rst_async_oe: uio_oe=%h expected c0", uio_oe); end
    step(2);
    rst_n = 1'b1;
    step(2);
    vecs++;
    if (uo_out !== 8'h00) begin errs++; $display("FAIL rst_no_tick: uo_out=%h expected 00", uo_out); end
    step(1);
    vecs++;
    if (uo_out !== 8'hFF || uio_out[7] !== 1'b1) begin
      errs++; $display("FAIL rst_first_tick: uo_out=%h tc=%b expected ff tc=1", uo_out, uio_out[7]);
    end
  endtask

  initial begin
    vecs   = 0;
    errs   = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    test_reset;
    test_wrap_up;
    test_sat_down;
    test_load_clear_priority;
    test_prescaler;
    test_ena_gating;
    test_reset_midcount;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
